hex_word_assembler: RTL
=======================

HEX_WORD_ASSEMBLER -- requirements
Module: hex_word_assembler

Interface
REQ-001 SHALL provide parameter DIGITS, default 2, maximum hex digits per word (range 1..8).
REQ-002 SHALL provide parameter DATA_W, default 4*DIGITS, output word width; it is not overridden independently.
REQ-003 SHALL have port clk  input  1  system clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port hex_valid  input  1  hex is valid this cycle (single-cycle strobe per received character).
REQ-006 SHALL have port hex  input  5 (data_hex_t)  code from ascii2hex: 0-15 digit, 30 separator, others invalid.
REQ-007 SHALL have port word_ready  input  1  downstream accepts word this cycle.
REQ-008 SHALL have port word  output  DATA_W  assembled value, zero-extended in the MSBs.
REQ-009 SHALL have port word_valid  output  1  word holds an unaccepted value.
REQ-010 SHALL have port ovf_err  output  1  one-cycle pulse: a digit beyond DIGITS was dropped.
REQ-011 SHALL have port drop_err  output  1  one-cycle pulse: a completed word was lost to output overrun.
REQ-012 SHALL have port word_cnt  output  8  emitted-word count (see Configuration).

Function
REQ-013 SHALL contain an accumulator FSM with states IDLE and ACCUM, a digit counter, and an output register separate from the accumulator.
REQ-014 IDLE + valid digit d SHALL load acc=d and cnt=1, then go to ACCUM.
REQ-015 IDLE + separator SHALL be ignored; empty words are never emitted.
REQ-016 ACCUM + digit with cnt<DIGITS SHALL set acc={acc[DATA_W-5:0],d} and cnt+1.
REQ-017 ACCUM + digit with cnt==DIGITS SHALL leave acc unchanged, pulse ovf_err the next cycle, and stay in ACCUM.
REQ-018 ACCUM + separator SHALL complete the word and return to IDLE; cnt is cleared.
REQ-019 Codes 16-29 and 31 SHALL be ignored in every state with no error and no state change.
REQ-020 Latency: when a separator is sampled at edge N, word and word_valid SHALL be updated at edge N+1.
REQ-021 word_valid SHALL stay high and word stable until sampled with word_ready=1; it clears on that edge unless a new word loads on the same edge.
REQ-022 Digits SHALL still be accepted while word_valid=1; upstream is never back-pressured.
REQ-023 On completion with word_valid=1 and word_ready=0, the new word SHALL be discarded, the old word kept, and drop_err pulsed.
REQ-024 On completion with word_valid=1 and word_ready=1 on the same edge, the new word SHALL load and word_valid SHALL stay 1 with no drop_err.
REQ-025 hex_valid=0 SHALL leave all state unchanged regardless of hex.

Reset
REQ-026 rst SHALL asynchronously force the FSM to IDLE and set acc=0, cnt=0, word=0, word_valid=0, ovf_err=0, drop_err=0, word_cnt=0.
REQ-027 Assertion mid-word SHALL discard the partial word; no word is emitted after release until a new digit and separator arrive.

Configuration
REQ-028 With macro MXV_HEXASM_STATS_EN defined, word_cnt SHALL increment by 1 on each word loaded into the output register and wrap from 255 to 0; dropped words are not counted.
REQ-029 Without MXV_HEXASM_STATS_EN, word_cnt SHALL be tied to 0 and no counter logic is built; the port list is unchanged.

Structure
REQ-030 mxv_pkg SHALL hold data_hex_t, the constant HEX_SEP=5'd30, and the enum hexasm_state_t {IDLE, ACCUM}.
REQ-031 The block SHALL be a single module with no sub-module; it instantiates next to ascii2hex with a direct hex connection.

Verification (DIGITS=2)
REQ-032 Input 0xA, 0x5, sep with word_ready=1 -> word=0xA5 and word_valid=1 exactly one cycle after sep is sampled.
REQ-033 Input 1, 2, 3, sep -> ovf_err pulses once after digit 3 and word=0x12.
REQ-034 Input sep, sep, 7, sep -> exactly one word, 0x07.
REQ-035 Input "C sep" then "D sep" with word_ready=0 -> word stays 0x0C and drop_err pulses once; then "E sep" completing on the same edge as word_ready=1 -> word=0x0E with word_valid continuously high.
REQ-036 Input 4, then rst pulse, then 9, sep -> word=0x09 and all outputs are 0 during reset.
REQ-037 With MXV_HEXASM_STATS_EN, 257 emitted words -> word_cnt=1; without the macro -> word_cnt=0 throughout.

Source files
------------

// File: rtl/mxv_pkg.sv
// mxv_pkg -- shared types for the hex word assembler.
//   data_hex_t     : 5-bit code from ascii2hex (0-15 digit, 30 separator, rest invalid)
//   HEX_SEP        : separator code
//   hexasm_state_t : accumulator FSM states
package mxv_pkg;

  typedef logic [4:0] data_hex_t;

  localparam data_hex_t HEX_SEP = 5'd30;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } hexasm_state_t;

endpackage

// File: rtl/hex_word_assembler.sv
// hex_word_assembler -- packs a stream of hex digit codes into words.
// Digits are shifted in MSB-first until a separator completes the word,
// which is then handed to a one-entry output register with valid/ready.
// Optional feature macro: MXV_HEXASM_STATS_EN (emitted-word counter on word_cnt).
//
// Ports:
//   clk        in   system clock, rising edge
//   rst        in   asynchronous active-high reset
//   hex_valid  in   hex carries a received character this cycle
//   hex        in   data_hex_t code from ascii2hex
//   word_ready in   downstream accepts word this cycle
//   word       out  assembled value, zero-extended in the MSBs
//   word_valid out  word holds an unaccepted value
//   ovf_err    out  one-cycle pulse: digit beyond DIGITS dropped
//   drop_err   out  one-cycle pulse: completed word lost to overrun
//   word_cnt   out  emitted-word count (0 when stats are not built)
//
// state | meaning
// IDLE  | no partial word; separators ignored
// ACCUM | at least one digit collected; separator completes the word
module hex_word_assembler
  import mxv_pkg::*;
#(
  parameter int DIGITS = 2,
  parameter int DATA_W = 4 * DIGITS
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              hex_valid,
  input  data_hex_t         hex,
  input  logic              word_ready,
  output logic [DATA_W-1:0] word,
  output logic              word_valid,
  output logic              ovf_err,
  output logic              drop_err,
  output logic [7:0]        word_cnt
);

  localparam int CNT_W = $clog2(DIGITS + 1);

  hexasm_state_t     state;
  logic [DATA_W-1:0] acc;
  logic [CNT_W-1:0]  cnt;

  logic              is_digit;
  logic              is_sep;
  logic              word_done;
  logic              word_load;
  logic [DATA_W+3:0] acc_ext;

  assign is_digit  = hex_valid && !hex[4];
  assign is_sep    = hex_valid && (hex == HEX_SEP);
  assign word_done = (state == ACCUM) && is_sep;
  // The output register can take a new word when empty or being drained now.
  assign word_load = word_done && (!word_valid || word_ready);
  // Concatenate then truncate so DIGITS=1 needs no special-case slice.
  assign acc_ext   = {acc, hex[3:0]};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      acc        <= '0;
      cnt        <= '0;
      word       <= '0;
      word_valid <= 1'b0;
      ovf_err    <= 1'b0;
      drop_err   <= 1'b0;
    end else begin
      ovf_err  <= 1'b0;
      drop_err <= 1'b0;

      if (word_valid && word_ready) begin
        word_valid <= 1'b0;
      end

      case (state)
        IDLE: begin
          if (is_digit) begin
            acc   <= DATA_W'(hex[3:0]);
            cnt   <= CNT_W'(1);
            state <= ACCUM;
          end
        end
        ACCUM: begin
          if (is_digit) begin
            if (cnt == CNT_W'(DIGITS)) begin
              ovf_err <= 1'b1;
            end else begin
              acc <= acc_ext[DATA_W-1:0];
              cnt <= cnt + CNT_W'(1);
            end
          end else if (is_sep) begin
            state <= IDLE;
            cnt   <= '0;
            if (word_load) begin
              word       <= acc;
              word_valid <= 1'b1;
            end else begin
              drop_err <= 1'b1;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

`ifdef MXV_HEXASM_STATS_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      word_cnt <= '0;
    end else if (word_load) begin
      word_cnt <= word_cnt + 8'd1;
    end
  end
`else
  assign word_cnt = '0;
`endif

endmodule
